led_pattern_sequencer: RTL and testbench

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

---
 rtl/led_seq_pkg.sv | 74 +++++++
 rtl/led_seq_timer.sv | 35 +++
 rtl/led_pattern_sequencer.sv | 165 ++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// ---------------------------------------------------------------------------
// led_seq_pkg
// Shared definitions for the LED pattern sequencer:
//   - mode_e      : pattern update modes selected by the 'mode' input
//   - state_e     : sequencer FSM states
//   - RESP_*      : AXI write response codes
//   - LED_REG_ADDR: address of the LED register in the slave
//   - nextStep()  : computes the pattern that follows the current one
// ---------------------------------------------------------------------------
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'd0,
        MODE_COUNT  = 2'd1,
        MODE_ROTL   = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_RESP  = 2'd2,
        S_WAIT  = 2'd3
    } state_e;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;
    localparam logic [1:0]  RESP_DECERR  = 2'b11;

    localparam logic [31:0] LED_REG_ADDR = 32'h0000_0000;
    localparam logic [3:0]  LED_WSTRB    = 4'b0011;

    typedef struct packed {
        logic [15:0] pattern;
        logic        dirLeft;
    } step_t;

    // Bounce reverses at the edges: a set bit15 while moving left (or a set
    // bit0 while moving right) flips the direction and that same step
    // already moves the other way. An all-zero pattern never moves.
    function automatic step_t nextStep(input mode_e m, input logic [15:0] p,
                                       input logic dirLeft);
        step_t s;
        s.pattern = p;
        s.dirLeft = dirLeft;
        case (m)
            MODE_HOLD:   s.pattern = p;
            MODE_COUNT:  s.pattern = p + 16'd1;
            MODE_ROTL:   s.pattern = {p[14:0], p[15]};
            MODE_BOUNCE: begin
                if (p != 16'h0000) begin
                    if (dirLeft) begin
                        if (p[15]) begin
                            s.dirLeft = 1'b0;
                            s.pattern = {1'b0, p[15:1]};
                        end else begin
                            s.pattern = {p[14:0], 1'b0};
                        end
                    end else begin
                        if (p[0]) begin
                            s.dirLeft = 1'b1;
                            s.pattern = {p[14:0], 1'b0};
                        end else begin
                            s.pattern = {1'b0, p[15:1]};
                        end
                    end
                end
            end
            default:     s.pattern = p;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/led_seq_timer.sv
// ---------------------------------------------------------------------------
// led_seq_timer
// Down-counter that sets the gap between LED writes.
// Ports:
//   clk, resetn   : clock, synchronous active-low reset (count -> 0)
//   i_load        : load i_loadValue into the counter
//   i_loadValue   : reload value
//   o_done        : counter has reached zero
// The counter stops at zero and stays there until the next load.
// ---------------------------------------------------------------------------
module led_seq_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadValue,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/led_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// led_pattern_sequencer
// Periodically writes an evolving 16-bit LED pattern to an AXI4-Lite slave.
// Ports:
//   clk, resetn     : clock, synchronous active-low reset
//   enable          : 1 = run the sequence
//   mode            : 0 hold, 1 binary count, 2 rotate-left, 3 bounce
//   start_pattern   : first pattern, sampled when leaving IDLE
//   busy            : FSM is not idle
//   err             : sticky, set by any non-OKAY write response
//   pattern         : last pattern acknowledged by the slave
//   M_AXI_*         : AXI4-Lite write-address/data/response channels
// ---------------------------------------------------------------------------
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int PERIOD_CYCLES = 25000000,
    parameter int AW            = 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic [15:0]   start_pattern,
    output logic          busy,
    output logic          err,
    output logic [15:0]   pattern,

    output logic [AW-1:0] M_AXI_AWADDR,
    output logic          M_AXI_AWVALID,
    input  logic          M_AXI_AWREADY,
    output logic [2:0]    M_AXI_AWPROT,
    output logic [31:0]   M_AXI_WDATA,
    output logic          M_AXI_WVALID,
    output logic [3:0]    M_AXI_WSTRB,
    input  logic          M_AXI_WREADY,
    input  logic [1:0]    M_AXI_BRESP,
    input  logic          M_AXI_BVALID,
    output logic          M_AXI_BREADY
);

    // Wide enough to hold PERIOD_CYCLES-1.
    localparam int            TW           = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(PERIOD_CYCLES - 1);

    state_e      r_state;
    state_e      w_nextState;
    logic        r_awValid;
    logic        r_wValid;
    logic        r_err;
    logic        r_dirLeft;
    logic [15:0] r_pattern;
    logic [15:0] r_nextPattern;

    logic        w_awDone;
    logic        w_wDone;
    logic        w_bHandshake;
    logic        w_timerLoad;
    logic        w_timerDone;
    step_t       w_step;

    led_seq_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk         (clk),
        .resetn      (resetn),
        .i_load      (w_timerLoad),
        .i_loadValue (TIMER_RELOAD),
        .o_done      (w_timerDone)
    );

    // Next-state logic. A channel counts as done once its VALID has already
    // dropped or its handshake completes this cycle, so AW and W may finish
    // in either order. Leaving RESP checks enable again, so a run that was
    // disabled mid-transaction finishes the write and idles without waiting.
    always_comb begin
        w_nextState  = r_state;
        w_awDone     = !r_awValid || M_AXI_AWREADY;
        w_wDone      = !r_wValid  || M_AXI_WREADY;
        w_bHandshake = 1'b0;
        w_timerLoad  = 1'b0;
        w_step       = nextStep(mode_e'(mode), r_nextPattern, r_dirLeft);

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_nextState = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_awDone && w_wDone) begin
                    w_nextState = S_RESP;
                end
            end
            S_RESP: begin
                if (M_AXI_BVALID) begin
                    w_bHandshake = 1'b1;
                    w_timerLoad  = 1'b1;
                    w_nextState  = enable ? S_WAIT : S_IDLE;
                end
            end
            S_WAIT: begin
                if (w_timerDone) begin
                    w_nextState = enable ? S_WRITE : S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Both VALIDs rise together on entry to WRITE; each then drops on its
    // own handshake.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_awValid     <= 1'b0;
            r_wValid      <= 1'b0;
            r_err         <= 1'b0;
            r_dirLeft     <= 1'b1;
            r_pattern     <= 16'h0000;
            r_nextPattern <= 16'h0000;
        end else begin
            r_state <= w_nextState;

            if (r_state == S_IDLE && enable) begin
                r_nextPattern <= start_pattern;
                r_dirLeft     <= 1'b1;
            end

            if (w_nextState == S_WRITE && r_state != S_WRITE) begin
                r_awValid <= 1'b1;
                r_wValid  <= 1'b1;
            end else begin
                if (r_awValid && M_AXI_AWREADY) begin
                    r_awValid <= 1'b0;
                end
                if (r_wValid && M_AXI_WREADY) begin
                    r_wValid <= 1'b0;
                end
            end

            if (w_bHandshake) begin
                r_pattern     <= r_nextPattern;
                r_nextPattern <= w_step.pattern;
                r_dirLeft     <= w_step.dirLeft;
                if (M_AXI_BRESP != RESP_OKAY) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign err           = r_err;
    assign pattern       = r_pattern;

    assign M_AXI_AWADDR  = AW'(LED_REG_ADDR);
    assign M_AXI_AWVALID = r_awValid;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_WDATA   = {16'h0000, r_nextPattern};
    assign M_AXI_WVALID  = r_wValid;
    assign M_AXI_WSTRB   = LED_WSTRB;
    assign M_AXI_BREADY  = (r_state == S_RESP);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_sequencer
// Self-checking bench for led_pattern_sequencer with a small AXI4-Lite
// slave model (programmable AW/W ready delays, error injection, B stall)
// and a behavioural model of the pattern rules.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_led_pattern_sequencer;
    import led_seq_pkg::*;

    localparam int PERIOD = 4;
    localparam int AW     = 4;

    logic          clk          = 1'b0;
    logic          resetn       = 1'b0;
    logic          enable       = 1'b0;
    logic [1:0]    mode         = 2'd0;
    logic [15:0]   startPattern = 16'h0000;
    logic          busy;
    logic          err;
    logic [15:0]   pattern;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready      = 1'b0;
    logic [2:0]    awprot;
    logic [31:0]   wdata;
    logic          wvalid;
    logic          wready       = 1'b0;
    logic [3:0]    wstrb;
    logic [1:0]    bresp        = 2'b00;
    logic          bvalid       = 1'b0;
    logic          bready;

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .PERIOD_CYCLES (PERIOD),
        .AW            (AW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .mode          (mode),
        .start_pattern (startPattern),
        .busy          (busy),
        .err           (err),
        .pattern       (pattern),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready)
    );

    int nChecks = 0;
    int nFails  = 0;
    int cycle   = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Slave knobs and bookkeeping
    int          awDelay  = 0;
    int          wDelay   = 0;
    int          errIndex = -1;
    bit          noB      = 1'b0;
    int          awCnt    = 0;
    int          wCnt     = 0;
    bit          awDone   = 1'b0;
    bit          wDone    = 1'b0;
    bit          bHs      = 1'b0;
    int          bCount   = 0;
    int          awCount  = 0;
    logic [15:0] wLog[$];
    int          wTime[$];
    logic [15:0] lastW    = 16'h0000;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference pattern rules, dir = +1 for left, -1 for right
    task automatic refStep(input int m, input int p, input int dirIn,
                           output int pOut, output int dirOut);
        dirOut = dirIn;
        case (m)
            0:       pOut = p;
            1:       pOut = (p + 1) % 65536;
            2:       pOut = ((p * 2) % 65536) + (p / 32768);
            default: begin
                if (p == 0) begin
                    pOut = 0;
                end else begin
                    if (dirIn > 0 && p >= 32768)       dirOut = -1;
                    else if (dirIn < 0 && (p % 2) == 1) dirOut = 1;
                    pOut = (dirOut > 0) ? (p * 2) % 65536 : p / 2;
                end
            end
        endcase
    endtask

    // Slave: drives its outputs 1ns after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!resetn) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
                awCnt = 0; wCnt = 0; awDone = 1'b0; wDone = 1'b0; bHs = 1'b0;
            end else begin
                if (awvalid) begin awready = (awCnt >= awDelay); awCnt++; end
                else begin awready = 1'b0; awCnt = 0; end
                if (wvalid) begin wready = (wCnt >= wDelay); wCnt++; end
                else begin wready = 1'b0; wCnt = 0; end
                if (bHs) begin
                    bvalid = 1'b0; bresp = 2'b00; bHs = 1'b0;
                    awDone = 1'b0; wDone = 1'b0; bCount++;
                end else if (awDone && wDone && !bvalid && !noB) begin
                    bvalid = 1'b1;
                    bresp  = (bCount == errIndex) ? RESP_DECERR : RESP_OKAY;
                end
            end
        end
    end

    // Monitor: sees the values that the next rising edge will sample
    bit          prevAwPending = 1'b0;
    bit          prevWPending  = 1'b0;
    bit          patPending    = 1'b0;
    logic [15:0] patExpect     = 16'h0000;

    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (patPending) begin
                    checkOutput("patternTrack", pattern, patExpect);
                    patPending = 1'b0;
                end
                if (prevAwPending) checkOutput("awvalidHeld", awvalid, 1);
                if (prevWPending)  checkOutput("wvalidHeld", wvalid, 1);
                if (!busy || awvalid || wvalid) checkOutput("breadyOnlyInResp", bready, 0);
                if (awvalid && awready) begin
                    awDone = 1'b1;
                    awCount++;
                    checkOutput("awaddr", awaddr, 0);
                    checkOutput("awprot", awprot, 0);
                end
                if (wvalid && wready) begin
                    wDone = 1'b1;
                    lastW = wdata[15:0];
                    wLog.push_back(wdata[15:0]);
                    wTime.push_back(cycle);
                    checkOutput("wstrb", wstrb, 4'b0011);
                    checkOutput("wdataUpper", wdata[31:16], 0);
                end
                if (bvalid && bready) begin
                    bHs        = 1'b1;
                    patPending = 1'b1;
                    patExpect  = lastW;
                end
                prevAwPending = awvalid && !awready;
                prevWPending  = wvalid && !wready;
            end else begin
                prevAwPending = 1'b0;
                prevWPending  = 1'b0;
                patPending    = 1'b0;
            end
        end
    end

    task automatic clearLog();
        wLog.delete();
        wTime.delete();
        awCount = 0;
    endtask

    task automatic waitIdle(input string tag);
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        checkOutput({tag, "_idle"}, busy, 0);
        @(negedge clk);
    endtask

    // Run one sequence from IDLE until nW writes were seen, then stop it
    task automatic applyStimulus(input int m, input logic [15:0] sp, input int nW,
                                 input int aD, input int wD);
        awDelay = aD;
        wDelay  = wD;
        clearLog();
        @(negedge clk);
        mode         = 2'(m);
        startPattern = sp;
        enable       = 1'b1;
        for (int i = 0; i < 2000 && wLog.size() < nW; i++) @(negedge clk);
        checkOutput("writesReached", (wLog.size() >= nW), 1);
        enable = 1'b0;
        waitIdle("run");
    endtask

    task automatic checkRun(input string tag, input int m, input logic [15:0] sp,
                            input int nW, input int aD, input int wD);
        int p;
        int dir;
        int pn;
        int dn;
        int gap;
        p   = int'(sp);
        dir = 1;
        gap = PERIOD + 2 + ((aD > wD) ? aD : wD);
        checkOutput({tag, "_awCount"}, awCount, wLog.size());
        for (int i = 0; i < nW && i < wLog.size(); i++) begin
            checkOutput({tag, "_write"}, wLog[i], 32'(p));
            if (i > 0) checkOutput({tag, "_gap"}, wTime[i] - wTime[i-1], gap);
            refStep(m, p, dir, pn, dn);
            p   = pn;
            dir = dn;
        end
    endtask

    typedef struct packed {
        logic [1:0]        m;
        logic [15:0]       sp;
        logic [2:0]        n;
        logic [3:0][15:0]  expw;
    } vec_t;

    vec_t        vecs[4];
    logic [15:0] edgeStarts[4];

    initial begin
        vecs[0] = '{m: 2'd1, sp: 16'hFFFE, n: 3'd3, expw: {16'h0000, 16'h0000, 16'hFFFF, 16'hFFFE}};
        vecs[1] = '{m: 2'd2, sp: 16'h8001, n: 3'd3, expw: {16'h0000, 16'h0006, 16'h0003, 16'h8001}};
        vecs[2] = '{m: 2'd3, sp: 16'h4000, n: 3'd4, expw: {16'h2000, 16'h4000, 16'h8000, 16'h4000}};
        vecs[3] = '{m: 2'd3, sp: 16'h0000, n: 3'd4, expw: {16'h0000, 16'h0000, 16'h0000, 16'h0000}};
        edgeStarts[0] = 16'h0000;
        edgeStarts[1] = 16'h8000;
        edgeStarts[2] = 16'h0001;
        edgeStarts[3] = 16'hFFFF;

        // Reset state
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstErr", err, 0);
        checkOutput("rstPattern", pattern, 0);
        checkOutput("rstAwvalid", awvalid, 0);
        checkOutput("rstWvalid", wvalid, 0);
        checkOutput("rstBready", bready, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Directed vectors
        for (int k = 0; k < 4; k++) begin
            applyStimulus(int'(vecs[k].m), vecs[k].sp, int'(vecs[k].n), 0, 0);
            for (int i = 0; i < int'(vecs[k].n) && i < wLog.size(); i++)
                checkOutput("tableWrite", wLog[i], vecs[k].expw[i]);
            checkOutput("tableErr", err, 0);
        end

        // Randomized runs against the reference model
        for (int r = 0; r < 12; r++) begin
            int          m;
            int          aD;
            int          wD;
            logic [15:0] sp;
            m  = int'($urandom_range(0, 3));
            sp = 16'($urandom);
            if (r % 3 == 2) sp = edgeStarts[$urandom_range(0, 3)];
            aD = int'($urandom_range(0, 2));
            wD = int'($urandom_range(0, 2));
            applyStimulus(m, sp, 5, aD, wD);
            checkRun("rand", m, sp, 5, aD, wD);
        end

        // WREADY three cycles ahead of AWREADY, single write
        awDelay = 3;
        wDelay  = 0;
        clearLog();
        @(negedge clk);
        mode = 2'd1; startPattern = 16'h1234; enable = 1'b1;
        for (int i = 0; i < 20 && !awvalid; i++) @(negedge clk);
        enable = 1'b0;
        checkOutput("stallWHandshake", (wvalid && wready && !awready), 1);
        @(negedge clk);
        checkOutput("stallWvalidDrop", wvalid, 0);
        checkOutput("stallAwvalidHeld", awvalid, 1);
        waitIdle("stall");
        checkOutput("stallWrites", wLog.size(), 1);
        checkOutput("stallAwCount", awCount, 1);
        checkOutput("stallPattern", pattern, 16'h1234);
        awDelay = 0;

        // Error response on the second write does not stop the sequence
        errIndex = bCount + 1;
        applyStimulus(1, 16'h0010, 3, 0, 0);
        checkRun("errRun", 1, 16'h0010, 3, 0, 0);
        checkOutput("errSticky", err, 1);
        errIndex = -1;

        // enable dropped in the first WRITE cycle
        clearLog();
        @(negedge clk);
        mode = 2'd2; startPattern = 16'h0F0F; enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        checkOutput("dropAwvalid", awvalid, 1);
        for (int i = 0; i < 50 && !(bvalid && bready); i++) @(negedge clk);
        checkOutput("dropBHandshake", (bvalid && bready), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("dropBusy", busy, 0);
        repeat (3 * PERIOD + 10) @(negedge clk);
        checkOutput("dropWrites", wLog.size(), 1);
        checkOutput("dropPattern", pattern, 16'h0F0F);
        checkOutput("dropStillIdle", busy, 0);

        // Reset while waiting for the write response
        noB = 1'b1;
        @(negedge clk);
        mode = 2'd1; startPattern = 16'h00AA; enable = 1'b1;
        for (int i = 0; i < 50 && !bready; i++) @(negedge clk);
        checkOutput("rrInResp", bready, 1);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rrBusy", busy, 0);
        checkOutput("rrErr", err, 0);
        checkOutput("rrPattern", pattern, 0);
        checkOutput("rrAwvalid", awvalid, 0);
        checkOutput("rrWvalid", wvalid, 0);
        checkOutput("rrBready", bready, 0);
        enable = 1'b0;
        noB    = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d failures %0d", nChecks, nFails);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
